// File: rtl/tap_mac_sched.sv
// Time-multiplexed FIR MAC sequencer: one shared multiplier stepped
// across all taps per sample, then one scaler pass to form y[n].
module tap_mac_sched #(
   parameter int TAPS = 8,
   parameter int DW   = 14,
   parameter int AW   = 28,
   parameter int CAW  = 3
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           in_valid,
   input  logic [DW-1:0]  in_data,
   output logic           in_ready,
   input  logic           coef_we,
   input  logic [CAW-1:0] coef_addr,
   input  logic [DW-1:0]  coef_data,
   output logic [AW-1:0]  div_in,
   input  logic [DW-1:0]  div_out,
   output logic           out_valid,
   output logic [DW-1:0]  out_data,
   output logic           busy
);

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      SCALE
   } state_t;

   state_t         state;
   logic [CAW-1:0] idx;
   logic [AW-1:0]  acc;
   logic [DW-1:0]  x [TAPS];
   logic [DW-1:0]  w [TAPS];
   logic [AW-1:0]  prod;
   logic           coef_ok;

   assign in_ready = (state == IDLE);
   assign busy     = ~in_ready;
   assign div_in   = acc;
   assign prod     = AW'(x[idx]) * AW'(w[idx]);
   assign coef_ok  = coef_we && (32'(coef_addr) < TAPS);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         idx       <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         for (int k = 0; k < TAPS; k++) begin
            x[k] <= '0;
            w[k] <= '0;
         end
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               // a write on the accept edge is visible to this same pass
               if (coef_ok) begin
                  w[coef_addr] <= coef_data;
               end
               if (in_valid) begin
                  for (int k = 1; k < TAPS; k++) begin
                     x[k] <= x[k-1];
                  end
                  x[0]  <= in_data;
                  acc   <= '0;
                  idx   <= '0;
                  state <= MAC;
               end
            end
            MAC: begin
               acc <= acc + prod;
               if (idx == CAW'(TAPS - 1)) begin
                  idx   <= '0;
                  state <= SCALE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            SCALE: begin
               out_data  <= div_out;
               out_valid <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tap_mac_sched.sv
// Randomized scoreboard bench for tap_mac_sched against a
// sum-of-products reference model of the FIR.
module tb_tap_mac_sched;
   localparam int TAPS = 8;
   localparam int DW   = 14;
   localparam int AW   = 28;
   localparam int CAW  = 3;

   logic           clk = 1'b0;
   logic           rstn = 1'b0;
   logic           in_valid = 1'b0;
   logic [DW-1:0]  in_data = '0;
   logic           in_ready;
   logic           coef_we = 1'b0;
   logic [CAW-1:0] coef_addr = '0;
   logic [DW-1:0]  coef_data = '0;
   logic [AW-1:0]  div_in;
   logic [DW-1:0]  div_out;
   logic           out_valid;
   logic [DW-1:0]  out_data;
   logic           busy;

   tap_mac_sched #(
      .TAPS(TAPS), .DW(DW), .AW(AW), .CAW(CAW)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .coef_we(coef_we),
      .coef_addr(coef_addr),
      .coef_data(coef_data),
      .div_in(div_in),
      .div_out(div_out),
      .out_valid(out_valid),
      .out_data(out_data),
      .busy(busy)
   );

   // external Q15 scaler
   assign div_out = {1'b0, div_in[AW-1:15]};

   always #5 clk = ~clk;

   typedef struct {
      longint unsigned acc;
      longint unsigned y;
   } exp_t;

   longint unsigned mx [TAPS];
   longint unsigned mw [TAPS];
   int   busy_left = 0;
   bit   exp_ov = 1'b0;
   exp_t sbq [$];
   int   vectors = 0;
   int   errors = 0;

   function automatic void model_reset();
      for (int k = 0; k < TAPS; k++) begin
         mx[k] = 0;
         mw[k] = 0;
      end
      busy_left = 0;
      exp_ov = 1'b0;
      sbq.delete();
   endfunction

   function automatic exp_t model_filter();
      exp_t e;
      longint unsigned s = 0;
      for (int k = 0; k < TAPS; k++) s += mx[k] * mw[k];
      e.acc = s % (64'd1 << AW);
      e.y   = e.acc / 32768;
      return e;
   endfunction

   task automatic step(input bit iv, input int unsigned d,
                       input bit we, input int unsigned a,
                       input int unsigned cd);
      in_valid  = iv;
      in_data   = DW'(d);
      coef_we   = we;
      coef_addr = CAW'(a);
      coef_data = DW'(cd);
      @(posedge clk);
      if (busy_left == 0) begin
         exp_ov = 1'b0;
         if (we) mw[a % TAPS] = cd % 16384;
         if (iv) begin
            for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
            mx[0] = d % 16384;
            sbq.push_back(model_filter());
            busy_left = TAPS + 1;
         end
      end else begin
         busy_left--;
         exp_ov = (busy_left == 0);
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 0, 1'b0, 0, 0);
   endtask

   task automatic send(input int unsigned d);
      step(1'b1, d, 1'b0, 0, 0);
      idle(TAPS + 1);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      coef_we  = 1'b0;
      #2;
      rstn = 1'b0;
      model_reset();
      @(negedge clk);
      vectors++;
      if (out_data !== '0 || div_in !== '0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_regs out_data=%0d div_in=%0d out_valid=%0b need 0/0/0",
                  out_data, div_in, out_valid);
      end
      @(negedge clk);
      rstn = 1'b1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      vectors++;
      if (in_ready !== (busy_left == 0) || busy !== (busy_left != 0) ||
          out_valid !== exp_ov) begin
         errors++;
         $display("FAIL ctrl t=%0t in_ready=%0b busy=%0b out_valid=%0b need %0b/%0b/%0b",
                  $time, in_ready, busy, out_valid,
                  busy_left == 0, busy_left != 0, exp_ov);
      end
      if (out_valid === 1'b1) begin
         vectors++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out t=%0t out_data=%0d need no output",
                     $time, out_data);
         end else begin
            e = sbq.pop_front();
            if (64'(out_data) !== e.y || 64'(div_in) !== e.acc) begin
               errors++;
               $display("FAIL data t=%0t out_data=%0d acc=%0d need %0d/%0d",
                        $time, out_data, div_in, e.y, e.acc);
            end
         end
      end
   end

   initial begin
      model_reset();
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      idle(2);

      // single tap: 8192*8192 >> 15 = 2048
      step(1'b0, 0, 1'b1, 0, 8192);
      send(8192);

      // all taps 8192, constant 4096: ramp up then wrap to zero
      do_reset();
      for (int k = 0; k < TAPS; k++) step(1'b0, 0, 1'b1, k, 8192);
      repeat (TAPS) send(4096);

      // largest product
      do_reset();
      step(1'b0, 0, 1'b1, 0, 16383);
      send(16383);

      // back-to-back accepts with in_valid held high
      for (int i = 0; i < 3 * (TAPS + 2); i++) step(1'b1, 100 + i, 1'b0, 0, 0);
      idle(TAPS + 2);

      // write during MAC ignored, write with accept used
      step(1'b1, 500, 1'b0, 0, 0);
      step(1'b0, 0, 1'b1, 0, 5);
      step(1'b0, 0, 1'b1, 1, 9);
      idle(TAPS);
      step(1'b1, 700, 1'b1, 0, 7);
      idle(TAPS + 1);

      // reset mid-pass, then zero-coefficient pass
      step(1'b1, 3000, 1'b0, 0, 0);
      idle(3);
      do_reset();
      send(1234);

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            step($urandom_range(0, 1) == 1, $urandom_range(0, 16383),
                 $urandom_range(0, 3) == 0, $urandom_range(0, TAPS - 1),
                 $urandom_range(0, 16383));
         end
      end

      idle(TAPS + 3);
      vectors++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d need 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
